hdx_diff_link_ctrl: RTL and testbench

- Half-duplex serial link controller driving one bidirectional differential pad pair through a tristate differential IO buffer.
- Owns the buffer's data-in (pad_o), tristate (pad_t) and data-out (pad_i) pins.
- Serializes bytes onto the pair as UART-style frames, releases the line after each frame with a turnaround guard, and deserializes incoming frames while the line is released.
- Sits directly upstream of the IO buffer; its byte-side interface faces user logic.

---
 rtl/hdx_pkg.sv | 14 +
 rtl/hdx_rx.sv | 92 +++++++++
 rtl/hdx_diff_link_ctrl.sv | 89 ++++++++
 tb/tb_hdx_diff_link_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hdx_pkg.sv
// hdx_pkg: shared types and constants for the half-duplex link; HDX_PARITY_EN adds an even-parity bit
package hdx_pkg;
  localparam int DATA_BITS = 8;
`ifdef HDX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP, T_TURN} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAITHI} rx_state_t;
  function automatic int timer_w(input int clks_per_bit, input int turn_bits);
    return $clog2(turn_bits * clks_per_bit);
  endfunction
endpackage

// File: rtl/hdx_rx.sv
// hdx_rx: pad synchronizer and frame receiver with stop/parity flags; parity check under HDX_PARITY_EN
module hdx_rx
  import hdx_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 100,
  parameter int TURNAROUND_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pad_i,
  output logic       line,
  output logic       idle,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_parity_err
);
  localparam int W = timer_w(CLKS_PER_BIT, TURNAROUND_BITS);
  localparam logic [W-1:0] BIT_LOAD  = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_LOAD = W'(CLKS_PER_BIT / 2 - 1);
`ifdef HDX_PARITY_EN
  localparam rx_state_t AFTER_DATA = R_PAR;
`else
  localparam rx_state_t AFTER_DATA = R_STOP;
`endif
  rx_state_t rs, rs_n;
  logic s1, tick, stop_ok, pe;
  logic [W-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  assign tick = cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1   <= 1'b1;
      line <= 1'b1;
    end else begin
      s1   <= pad_i;
      line <= s1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rs           <= R_IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rs           <= rs_n;
      cnt          <= rs_n != rs ? (rs_n == R_START ? HALF_LOAD : BIT_LOAD) : tick ? BIT_LOAD : cnt - W'(1);
      idx          <= rs == R_START ? 3'd0 : rs == R_DATA && tick ? idx + 3'd1 : idx;
      rx_valid     <= stop_ok && !pe;
      rx_frame_err <= rs == R_STOP && tick && !line;
      if (rs == R_DATA && tick) sh <= {line, sh[7:1]};
      if (stop_ok && !pe) rx_data <= sh;
    end
  // a disabled receiver (own frame on the pair) is pinned to idle
  always_comb begin
    rs_n = rs;
    case (rs)
      R_IDLE:   rs_n = line ? R_IDLE : R_START;
      R_START:  if (tick) rs_n = line ? R_IDLE : R_DATA;
      R_DATA:   if (tick && idx == 3'd7) rs_n = AFTER_DATA;
      R_PAR:    if (tick) rs_n = R_STOP;
      R_STOP:   if (tick) rs_n = line ? R_IDLE : R_WAITHI;
      R_WAITHI: if (line) rs_n = R_IDLE;
      default:  rs_n = R_IDLE;
    endcase
    if (!en) rs_n = R_IDLE;
  end
  always_comb begin
    idle    = rs == R_IDLE;
    stop_ok = rs == R_STOP && tick && line;
  end
`ifdef HDX_PARITY_EN
  logic par;
  assign pe = ^{sh, par};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      par           <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      if (rs == R_PAR && tick) par <= line;
      rx_parity_err <= stop_ok && pe;
    end
`else
  assign pe            = 1'b0;
  assign rx_parity_err = 1'b0;
`endif
endmodule

// File: rtl/hdx_diff_link_ctrl.sv
// hdx_diff_link_ctrl: half-duplex UART-style link over a tristate differential pad pair
// HDX_PARITY_EN inserts and checks an even-parity bit.
module hdx_diff_link_ctrl
  import hdx_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 100,
  parameter int TURNAROUND_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       busy,
  output logic       pad_o,
  output logic       pad_t,
  input  logic       pad_i
);
  localparam int W = timer_w(CLKS_PER_BIT, TURNAROUND_BITS);
  localparam logic [W-1:0] BIT_LOAD  = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] TURN_LOAD = W'(TURNAROUND_BITS * CLKS_PER_BIT - 1);
`ifdef HDX_PARITY_EN
  localparam tx_state_t AFTER_DATA = T_PAR;
`else
  localparam tx_state_t AFTER_DATA = T_STOP;
`endif
  tx_state_t ts, ts_n;
  logic [W-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic par, tick, accept, rx_line, rx_idle;
  assign tick   = cnt == '0;
  assign accept = tx_valid && tx_ready;
  hdx_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .TURNAROUND_BITS(TURNAROUND_BITS)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .en           (ts == T_IDLE),
    .pad_i        (pad_i),
    .line         (rx_line),
    .idle         (rx_idle),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ts  <= T_IDLE;
      cnt <= '0;
      idx <= '0;
      sh  <= '0;
      par <= 1'b0;
    end else begin
      ts  <= ts_n;
      cnt <= ts_n != ts ? (ts_n == T_TURN ? TURN_LOAD : BIT_LOAD) : tick ? BIT_LOAD : cnt - W'(1);
      if (ts == T_DATA && tick) begin
        sh  <= sh >> 1;
        idx <= idx + 3'd1;
      end
      if (accept) begin
        sh  <= tx_data;
        par <= ^tx_data;
        idx <= '0;
      end
    end
  always_comb begin
    ts_n = ts;
    case (ts)
      T_IDLE:  ts_n = accept ? T_START : T_IDLE;
      T_START: if (tick) ts_n = T_DATA;
      T_DATA:  if (tick && idx == 3'd7) ts_n = AFTER_DATA;
      T_PAR:   if (tick) ts_n = T_STOP;
      T_STOP:  if (tick) ts_n = T_TURN;
      T_TURN:  if (tick) ts_n = T_IDLE;
      default: ts_n = T_IDLE;
    endcase
  end
  // a low synced line means a frame is arriving, so the receiver wins over tx_valid
  always_comb begin
    tx_ready = ts == T_IDLE && rx_idle && rx_line;
    busy     = ts != T_IDLE || !rx_idle;
    pad_t    = !(ts inside {T_START, T_DATA, T_PAR, T_STOP});
    pad_o    = ts == T_START ? 1'b0 : ts == T_DATA ? sh[0] : ts == T_PAR ? par : 1'b1;
  end
endmodule

// File: tb/tb_hdx_diff_link_ctrl.sv
// tb_hdx_diff_link_ctrl: randomized self-checking bench against a frame-level model of the link
module tb_hdx_diff_link_ctrl;
  localparam int CPB = 4;
  localparam int TB  = 2;
`ifdef HDX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 10 + PB;
  logic clk = 1'b0, rst = 1'b1, tx_valid = 1'b0, pad_i = 1'b1, loop = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic tx_ready, rx_valid, rx_frame_err, rx_parity_err, busy, pad_o, pad_t, pad_in;
  int n_chk = 0, n_pass = 0, nv = 0, nf = 0, np = 0;
  logic [7:0] exp_rx = 8'h00;
  assign pad_in = loop ? pad_o : pad_i;
  hdx_diff_link_ctrl #(.CLKS_PER_BIT(CPB), .TURNAROUND_BITS(TB)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .busy(busy), .pad_o(pad_o), .pad_t(pad_t), .pad_i(pad_in)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) nv++;
    if (rx_frame_err) nf++;
    if (rx_parity_err) np++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  // line level for each bit period, index 0 = start bit
  function automatic logic [10:0] frame(input logic [7:0] d, input logic stop);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (PB == 1) f[9] = ^d;
    f[NB-1] = stop;
    return f;
  endfunction
  task automatic wait_ready();
    for (int i = 0; i < 200 && !tx_ready; i++) step();
    check("ready_wait", tx_ready, 1);
  endtask
  task automatic tx_frame(input string tag, input logic [7:0] d);
    logic [10:0] f;
    f = frame(d, 1'b1);
    for (int k = 0; k < NB * CPB; k++) begin
      check(tag, {pad_t, pad_o}, {1'b0, f[k/CPB]});
      step();
    end
    for (int k = 0; k < TB * CPB; k++) begin
      check({tag, "_turn"}, {pad_t, pad_o, tx_ready, busy}, 4'b1101);
      step();
    end
    check({tag, "_ready"}, {pad_t, tx_ready}, 2'b11);
  endtask
  task automatic do_tx(input string tag, input logic [7:0] d);
    wait_ready();
    tx_data = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    tx_frame(tag, d);
  endtask
  task automatic send_rx(input logic [7:0] d, input logic stop, input logic flip);
    logic [10:0] f;
    f = frame(d, stop);
    if (flip && NB == 11) f[9] = ~f[9];
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < CPB; c++) begin
        pad_i = f[b];
        step();
      end
    pad_i = 1'b1;
  endtask
  task automatic rx_case(input string tag, input logic [7:0] d, input logic stop, input logic flip, input int hold);
    int v0, f0, p0, ev, ef, ep;
    v0 = nv; f0 = nf; p0 = np;
    send_rx(d, stop, flip);
    if (hold > 0) begin
      pad_i = 1'b0;
      repeat (hold) step();
      check({tag, "_waithi_busy"}, busy, 1);
      pad_i = 1'b1;
    end
    repeat (6) step();
    ef = stop ? 0 : 1;
    ep = (stop && flip && NB == 11) ? 1 : 0;
    ev = (stop && ep == 0) ? 1 : 0;
    if (ev == 1) exp_rx = d;
    check({tag, "_valid"}, nv - v0, ev);
    check({tag, "_ferr"}, nf - f0, ef);
    check({tag, "_perr"}, np - p0, ep);
    check({tag, "_data"}, rx_data, exp_rx);
    check({tag, "_idle"}, busy, 0);
  endtask
  initial begin
    int v0, f0, p0;
    logic [10:0] f;
    logic [7:0] d;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_pads", {pad_t, pad_o, tx_ready, busy}, 4'b1110);
    check("rst_flags", {rx_valid, rx_frame_err, rx_parity_err}, 3'b000);
    check("rst_data", rx_data, 8'h00);
    do_tx("tx_a5", 8'hA5);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) step();
      do_tx("tx_rand", 8'($urandom));
    end
    rx_case("rx_3c", 8'h3C, 1'b1, 1'b0, 0);
    v0 = nv; f0 = nf; p0 = np;
    loop = 1'b1;
    do_tx("echo_55", 8'h55);
    do_tx("echo_rand", 8'($urandom));
    repeat (4) step();
    loop = 1'b0;
    check("echo_flags", {nv - v0, nf - f0, np - p0}, 0);
    rx_case("ferr_ff", 8'hFF, 1'b0, 1'b0, 12);
    v0 = nv; f0 = nf; p0 = np;
    pad_i = 1'b0;
    step();
    pad_i = 1'b1;
    repeat (8) step();
    check("glitch_flags", {nv - v0, nf - f0, np - p0}, 0);
    check("glitch_idle", {busy, tx_ready}, 2'b01);
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 6)) step();
      rx_case("rx_rand", 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 0);
    end
    d = 8'($urandom);
    f = frame(d, 1'b1);
    v0 = nv;
    for (int k = 0; k < NB * CPB; k++) begin
      pad_i = f[k/CPB];
      if (k == 12) begin
        tx_data = 8'h81;
        tx_valid = 1'b1;
      end
      step();
      if (k >= 12) check("col_blocked", {tx_ready, busy}, 2'b01);
    end
    pad_i = 1'b1;
    for (int i = 0; i < 20 && !tx_ready; i++) step();
    check("col_ready", tx_ready, 1);
    check("col_valid", nv - v0, 1);
    check("col_data", rx_data, d);
    exp_rx = d;
    step();
    tx_valid = 1'b0;
    tx_frame("col_tx81", 8'h81);
    v0 = nv; f0 = nf; p0 = np;
    wait_ready();
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (10) step();
    check("mid_drive", pad_t, 0);
    rst = 1'b1;
    #1;
    check("async_release", {pad_t, pad_o}, 2'b11);
    repeat (2) step();
    rst = 1'b0;
    exp_rx = 8'h00;
    repeat (3) step();
    check("mid_rst_state", {pad_t, pad_o, tx_ready, busy}, 4'b1110);
    check("mid_rst_data", rx_data, exp_rx);
    check("mid_rst_flags", {nv - v0, nf - f0, np - p0}, 0);
    do_tx("post_rst", 8'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
